// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//   Readback monitor for a time-multiplexed, active-low 7-segment display bus.
//   Each strobed sample is decoded back to a nibble and collected into a
//   per-digit shadow frame. A completed frame is compared with the previous
//   one, and is published only after it has been identical for STABLE_SCANS
//   consecutive scans.
//
//   Optional feature macro: SEG_SCAN_DP_EN
//     defined   : the decimal point is captured, takes part in the frame
//                 compare and is published on o_dp
//     undefined : the decimal point is ignored and o_dp is tied to 0
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   i_seg_en     sample strobe; i_digit_sel/i_seg valid when 1
//   i_digit_sel  one-hot digit select (bit k = digit k)
//   i_seg        segments, active-low, bit7..0 = a,b,c,d,e,f,g,dp
//   o_hex        published nibbles, digit k at [4k+3:4k]
//   o_invalid    digit k pattern is not one of the 16 hex glyphs
//   o_dp         published decimal points
//   o_valid      one-cycle pulse when new outputs are published
//   o_sel_err    sticky flag: strobe seen with a non-one-hot select
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned STABLE_SCANS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_seg_en,
    input  logic [DIGITS-1:0]     i_digit_sel,
    input  logic [7:0]            i_seg,
    output logic [4*DIGITS-1:0]   o_hex,
    output logic [DIGITS-1:0]     o_invalid,
    output logic [DIGITS-1:0]     o_dp,
    output logic                  o_valid,
    output logic                  o_sel_err
);

    // Shadow entry layout: [3:0] nibble, [4] invalid, [5] dp (when enabled)
`ifdef SEG_SCAN_DP_EN
    localparam int unsigned ENTRY_W = 6;
`else
    localparam int unsigned ENTRY_W = 5;
`endif

    localparam logic [3:0]        STABLE  = 4'(STABLE_SCANS);
    localparam logic [DIGITS-1:0] SEL_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

    // Returns {invalid, nibble} for an active-high abcdefg pattern
    function automatic logic [4:0] decode_glyph(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1110011: r = 5'h09;
            7'b1110111: r = 5'h0A;
            7'b0011111: r = 5'h0B;
            7'b1001110: r = 5'h0C;
            7'b0111101: r = 5'h0D;
            7'b1001111: r = 5'h0E;
            7'b1000111: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    logic [DIGITS-1:0][ENTRY_W-1:0] r_shadow;
    logic [DIGITS-1:0][ENTRY_W-1:0] r_snap;
    logic [DIGITS-1:0][ENTRY_W-1:0] r_prev;
    logic [DIGITS-1:0]              r_seen;
    logic                           r_frame_done;
    logic [3:0]                     r_cnt;
    logic [4*DIGITS-1:0]            r_hex;
    logic [DIGITS-1:0]              r_invalid;
    logic                           r_valid;
    logic                           r_sel_err;

    logic [ENTRY_W-1:0]             w_entry;
    logic                           w_onehot;
    logic                           w_sample;
    logic [DIGITS-1:0][ENTRY_W-1:0] w_shadow_next;
    logic [DIGITS-1:0]              w_seen_next;
    logic                           w_frame_cpl;
    logic [3:0]                     w_cnt_next;
    logic                           w_publish;
    logic [4*DIGITS-1:0]            w_pub_hex;
    logic [DIGITS-1:0]              w_pub_inv;

    always_comb begin
        w_entry      = '0;
        w_entry[4:0] = decode_glyph(~i_seg[7:1]);
`ifdef SEG_SCAN_DP_EN
        w_entry[5]   = ~i_seg[0];
`endif
        // Power-of-two test: exactly one bit set
        w_onehot = (i_digit_sel != '0) &&
                   ((i_digit_sel & (i_digit_sel - SEL_ONE)) == '0);
        w_sample = i_seg_en && w_onehot;

        w_shadow_next = r_shadow;
        w_seen_next   = r_seen;
        if (w_sample) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                if (i_digit_sel[k]) begin
                    w_shadow_next[k] = w_entry;
                    w_seen_next[k]   = 1'b1;
                end
            end
        end
        w_frame_cpl = w_sample && (&w_seen_next);

        if (r_snap == r_prev) begin
            w_cnt_next = (r_cnt == STABLE) ? r_cnt : r_cnt + 4'd1;
        end else begin
            w_cnt_next = 4'd1;
        end
        // Publish only on the transition into the stable count
        w_publish = r_frame_done && (w_cnt_next == STABLE) && (r_cnt != STABLE);

        w_pub_hex = '0;
        w_pub_inv = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_pub_hex[4*k +: 4] = r_snap[k][3:0];
            w_pub_inv[k]        = r_snap[k][4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow     <= '0;
            r_snap       <= '0;
            r_prev       <= '0;
            r_seen       <= '0;
            r_frame_done <= 1'b0;
            r_cnt        <= '0;
            r_hex        <= '0;
            r_invalid    <= '0;
            r_valid      <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_shadow <= w_shadow_next;
            if (w_frame_cpl) begin
                r_snap       <= w_shadow_next;
                r_seen       <= '0;
                r_frame_done <= 1'b1;
            end else begin
                r_seen       <= w_seen_next;
                r_frame_done <= 1'b0;
            end
            if (r_frame_done) begin
                r_cnt  <= w_cnt_next;
                r_prev <= r_snap;
            end
            r_valid <= w_publish;
            if (w_publish) begin
                r_hex     <= w_pub_hex;
                r_invalid <= w_pub_inv;
            end
            if (i_seg_en && !w_onehot) begin
                r_sel_err <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [DIGITS-1:0] r_dp;
    logic [DIGITS-1:0] w_pub_dp;

    always_comb begin
        w_pub_dp = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_pub_dp[k] = r_snap[k][5];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp <= '0;
        end else if (w_publish) begin
            r_dp <= w_pub_dp;
        end
    end

    assign o_dp = r_dp;
`else
    // Decimal point is not monitored in this build
    logic w_unused_dp;
    assign w_unused_dp = i_seg[0];
    assign o_dp        = '0;
`endif

    assign o_hex     = r_hex;
    assign o_invalid = r_invalid;
    assign o_valid   = r_valid;
    assign o_sel_err = r_sel_err;

endmodule
